rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL provide parameter INDEX, default 8'h00, ioctl_index value selecting this loader.
REQ-002 SHALL provide parameter PAGES, default 6, number of 16 KB source pages accepted (1..32).
REQ-003 SHALL provide parameter ADDR_W, default 23, target address width (page field = ADDR_W-14 bits).
REQ-004 SHALL provide parameter PAGE_MAP, default {9'h107,9'h100,9'h000,9'h107,9'h100,9'h000}, PAGES*(ADDR_W-14) bits, entry i = target page of source page i.
REQ-005 SHALL provide parameter BANK_MAP, default 6'b111000, PAGES bits, entry i = target bank of source page i.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 4, power of two >= 2.
REQ-007 SHALL provide ports: clk_sys in 1 system clock; reset in 1 synchronous active-high reset.
REQ-008 SHALL provide ports: ioctl_download in 1; ioctl_index in 8; ioctl_wr in 1 byte strobe; ioctl_addr in 25; ioctl_dout in 8.
REQ-009 SHALL provide ports: mem_we out 1 write request; mem_ack in 1 write accepted; mem_addr out ADDR_W; mem_bank out 1; mem_din out 8.
REQ-010 SHALL provide ports: hold_reset out 1 core reset request; busy out 1; done out 1 one-cycle pulse; err_ovf out 1 sticky; pages out 6 pages written; checksum out 16.

Function
REQ-011 SHALL use states IDLE, LOAD, DRAIN, DONE.
REQ-012 IDLE->LOAD on cycle ioctl_download=1 and ioctl_index==INDEX; entry clears err_ovf, pages, checksum.
REQ-013 LOAD->DRAIN when ioctl_download=0; DRAIN->DONE when FIFO empty and mem_we=0; DONE->IDLE next cycle.
REQ-014 DRAIN->LOAD if a matching download restarts; FIFO contents retained, err_ovf/pages/checksum cleared.
REQ-015 In LOAD, ioctl_wr=1 with ioctl_addr[24:14] < PAGES SHALL push {PAGE_MAP[p],ioctl_addr[13:0]}, BANK_MAP[p], ioctl_dout; p >= PAGES SHALL be dropped silently.
REQ-016 Push with FIFO full SHALL drop the byte and set err_ovf until next LOAD entry.
REQ-017 pages SHALL equal max accepted p + 1.
REQ-018 When mem_we=0 and FIFO non-empty, mem_we SHALL assert next cycle with head on mem_addr/mem_bank/mem_din.
REQ-019 mem_addr/mem_bank/mem_din SHALL hold stable while mem_we=1; mem_ack=1 SHALL pop head and drop mem_we next cycle; mem_ack with mem_we=0 ignored.
REQ-020 Minimum latency ioctl_wr to mem_we SHALL be 1 cycle (FIFO empty); back-to-back writes need >=1 idle cycle.
REQ-021 Simultaneous push and pop SHALL both occur; occupancy unchanged; push on full with same-cycle pop SHALL succeed.
REQ-022 hold_reset and busy SHALL be 1 in LOAD and DRAIN, 0 otherwise; done SHALL be 1 only in DONE.

Reset
REQ-023 reset SHALL force IDLE, flush FIFO, mem_we=0, hold_reset=0, busy=0, done=0, err_ovf=0, pages=0, checksum=0, mem_addr/mem_bank/mem_din=0 from the next edge.
REQ-024 reset mid-handshake SHALL abandon the outstanding write; no retry.

Configuration
REQ-025 With ROM_CHECKSUM_EN defined, checksum SHALL be the sum mod 2^16 of bytes accepted into FIFO since LOAD entry.
REQ-026 Without ROM_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be built.

Verification
REQ-027 Defaults; bytes 8'hA5 at addr 0 and 8'h5A at 25'h4000, mem_ack after 2 cycles -> writes (23'h000000,bank 0,A5), (23'h400000,bank 0,5A); pages=2; done pulse once.
REQ-028 Byte at 25'h0C000 (p=3) -> mem_addr 23'h000000, mem_bank 1; byte at 25'h18000 (p=6) -> no write.
REQ-029 mem_ack held 0, 5 consecutive ioctl_wr -> 4 queued, err_ovf=1; release ack -> exactly 4 writes, done pulse.
REQ-030 Download drops with 3 queued -> busy=1 until third ack; done 1 cycle after final mem_we falls.
REQ-031 reset while mem_we=1 -> next cycle mem_we=0, busy=0, FIFO empty; later ack ignored.
REQ-032 ROM_CHECKSUM_EN: bytes FF,FF,02 -> checksum 16'h0200; undefined -> 16'h0000.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: streams matching ioctl download bytes through a FIFO into paged memory writes; define ROM_CHECKSUM_EN to build the byte checksum
module rom_loader #(
   parameter logic [7:0]                     INDEX      = 8'h00,
   parameter int                             PAGES      = 6,
   parameter int                             ADDR_W     = 23,
   parameter logic [PAGES*(ADDR_W-14)-1:0]   PAGE_MAP   = {9'h107, 9'h100, 9'h000, 9'h107, 9'h100, 9'h000},
   parameter logic [PAGES-1:0]               BANK_MAP   = 6'b111000,
   parameter int                             FIFO_DEPTH = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_bank,
   output logic [7:0]        mem_din,
   output logic              hold_reset,
   output logic              busy,
   output logic              done,
   output logic              err_ovf,
   output logic [5:0]        pages,
   output logic [15:0]       checksum
);
   localparam int PW = ADDR_W - 14;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = ADDR_W + 9;
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   state_t            state_q;
   logic              hold_reset_q, busy_q, done_q, mem_we_q, mem_bank_q, err_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_din_q;
   logic [5:0]        pages_q;
   logic [EW-1:0]     fifo_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       cnt_q;
   logic [PW-1:0]     pmap [32];
   logic [31:0]       bmap;
   logic              match, clr, push_req, push_ok, pop, full, empty, start;
   logic [4:0]        pi;
   logic [5:0]        np;
   logic [EW-1:0]     push_e;
   // Unused source pages map to zero so the lookup is always in range
   for (genvar i = 0; i < 32; i++) begin : g_map
      if (i < PAGES) begin : g_used
         assign pmap[i] = PAGE_MAP[i*PW +: PW];
         assign bmap[i] = BANK_MAP[i];
      end else begin : g_unused
         assign pmap[i] = '0;
         assign bmap[i] = 1'b0;
      end
   end
   assign match    = ioctl_download && ioctl_index == INDEX;
   assign clr      = match && (state_q == IDLE || state_q == DRAIN);
   assign pi       = ioctl_addr[18:14];
   assign push_req = state_q == LOAD && ioctl_wr && ioctl_addr[24:14] < 11'(PAGES);
   assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign empty    = cnt_q == '0;
   assign pop      = mem_we_q && mem_ack;
   assign push_ok  = push_req && (!full || pop);
   assign start    = !mem_we_q && (!empty || push_ok);
   assign np       = {1'b0, pi} + 6'd1;
   assign push_e   = {pmap[pi], ioctl_addr[13:0], bmap[pi], ioctl_dout};
   // Download sequencing; status outputs are registered alongside the state
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (match) begin
               state_q      <= LOAD;
               hold_reset_q <= 1'b1;
               busy_q       <= 1'b1;
            end
            LOAD: if (!ioctl_download) state_q <= DRAIN;
            DRAIN: if (match) state_q <= LOAD;
               else if (empty && !mem_we_q) begin
                  state_q      <= DONE;
                  hold_reset_q <= 1'b0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
               end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // FIFO storage needs no reset; only occupied slots are ever read
   always_ff @(posedge clk_sys) begin
      if (push_ok) fifo_q[wr_q] <= push_e;
   end
   // FIFO pointers, memory handshake and status; an empty FIFO forwards the incoming byte straight to the bus
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_bank_q <= 1'b0;
         mem_din_q  <= '0;
         err_q      <= 1'b0;
         pages_q    <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
         if (start) begin
            mem_we_q <= 1'b1;
            {mem_addr_q, mem_bank_q, mem_din_q} <= empty ? push_e : fifo_q[rd_q];
         end else if (pop) mem_we_q <= 1'b0;
         err_q   <= clr ? 1'b0 : err_q | (push_req && full && !pop);
         pages_q <= clr ? '0 : (push_ok && np > pages_q) ? np : pages_q;
      end
   end
`ifdef ROM_CHECKSUM_EN
   logic [15:0] cks_q;
   // Running sum of every byte accepted since the download started
   always_ff @(posedge clk_sys) begin
      if (reset || clr) cks_q <= '0;
      else if (push_ok) cks_q <= cks_q + {8'h00, ioctl_dout};
   end
   assign checksum = cks_q;
`else
   assign checksum = 16'h0000;
`endif
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_bank   = mem_bank_q;
   assign mem_din    = mem_din_q;
   assign hold_reset = hold_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_ovf    = err_q;
   assign pages      = pages_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized downloads checked against a queue-based model of the loader's write stream
module tb_rom_loader;
   logic        clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, mem_ack = 1'b0;
   logic [7:0]  ioctl_index = 8'h00, ioctl_dout = 8'h00;
   logic [24:0] ioctl_addr = '0;
   logic        mem_we, mem_bank, hold_reset, busy, done, err_ovf;
   logic [22:0] mem_addr;
   logic [7:0]  mem_din;
   logic [5:0]  pages;
   logic [15:0] checksum;
   rom_loader dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_we(mem_we),
      .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_bank(mem_bank), .mem_din(mem_din),
      .hold_reset(hold_reset), .busy(busy), .done(done), .err_ovf(err_ovf), .pages(pages), .checksum(checksum)
   );
   always #5 clk_sys = ~clk_sys;
`ifdef ROM_CHECKSUM_EN
   localparam bit CK_ON = 1'b1;
`else
   localparam bit CK_ON = 1'b0;
`endif
   typedef struct packed {logic [22:0] a; logic b; logic [7:0] d;} wr_t;
   wr_t         exp_q[$];
   logic [24:0] ta[$];
   logic [7:0]  td[$];
   logic [8:0]  pg_tbl [6] = '{9'h000, 9'h100, 9'h107, 9'h000, 9'h100, 9'h107};
   bit          bk_tbl [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   int          n_chk = 0, n_fail = 0, n_wr = 0, n_done = 0, e_wr = 0, e_done = 0, cyc = 0, last_drop = 0;
   bit          hold_ack = 1'b0;
   always @(posedge clk_sys) cyc <= cyc + 1;
   always @(negedge clk_sys) if (done) n_done++;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask
   function automatic logic [15:0] ck_exp(input logic [15:0] s);
      return s & {16{CK_ON}};
   endfunction
   // Memory responder: checks each request against the model, holds it a random time, then acks
   initial begin : resp
      wr_t w;
      logic [31:0] cap;
      forever begin
         @(negedge clk_sys);
         if (mem_we && !hold_ack) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
               w = exp_q.pop_front();
               check("wr_data", {mem_addr, mem_bank, mem_din}, w);
            end
            cap = {mem_addr, mem_bank, mem_din};
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk_sys);
               check("wr_hold", {mem_we, mem_addr, mem_bank, mem_din}, {1'b1, cap});
            end
            mem_ack = 1'b1;
            @(negedge clk_sys);
            mem_ack = 1'b0;
            check("we_drop", mem_we, 0);
            n_wr++;
            last_drop = cyc;
         end
      end
   end
   // One download of the bytes in ta/td; with hold the responder is stalled until the download ends
   task automatic run_dl(input bit hold);
      int p, acc, k;
      logic [5:0] e_pages;
      logic [15:0] sum;
      bit e_err;
      acc = 0; e_pages = 0; sum = 0; e_err = 0;
      hold_ack = hold;
      tick();
      ioctl_download = 1'b1;
      ioctl_index = 8'h00;
      tick();
      check("busy_entry", {hold_reset, busy, done}, 3'b110);
      check("cleared_entry", {err_ovf, pages, checksum}, 0);
      for (int i = 0; i < ta.size(); i++) begin
         if (!hold) repeat ($urandom_range(0, 2)) tick();
         ioctl_wr = 1'b1;
         ioctl_addr = ta[i];
         ioctl_dout = td[i];
         p = int'(ta[i][24:14]);
         if (p < 6) begin
            if (hold && acc == 4) e_err = 1'b1;
            else begin
               acc++;
               e_wr++;
               exp_q.push_back({pg_tbl[p], ta[i][13:0], bk_tbl[p], td[i]});
               sum += {8'h00, td[i]};
               if (p + 1 > e_pages) e_pages = 6'(p + 1);
            end
         end
         tick();
         ioctl_wr = 1'b0;
      end
      ioctl_download = 1'b0;
      if (hold) begin
         repeat (3) tick();
         check("drain_wait", {busy, done, err_ovf}, {2'b10, e_err});
         hold_ack = 1'b0;
      end
      k = 0;
      while (!done && k < 300) begin
         check("busy_run", busy, 1);
         tick();
         k++;
      end
      check("done_seen", done, 1);
      if (hold && acc > 0) check("done_latency", cyc, last_drop + 1);
      check("done_state", {hold_reset, busy, mem_we}, 0);
      check("pending", exp_q.size(), 0);
      check("pages", pages, e_pages);
      check("err_ovf", err_ovf, e_err);
      check("checksum", checksum, ck_exp(sum));
      e_done++;
      tick();
      check("done_pulse", {done, busy}, 0);
   endtask
   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) tick();
      reset = 1'b0;
      check("reset_state", {mem_we, busy, hold_reset, done, err_ovf, pages, checksum, mem_addr, mem_bank, mem_din}, 0);
      ta = '{25'h0000000, 25'h0004000}; td = '{8'hA5, 8'h5A};
      run_dl(1'b0);
      ta = '{25'h000C000, 25'h0018000}; td = '{8'h3C, 8'hC3};
      run_dl(1'b0);
      ta = '{25'h0000000, 25'h0000001, 25'h0000002}; td = '{8'hFF, 8'hFF, 8'h02};
      run_dl(1'b0);
      ta = '{25'h0000010, 25'h0004020, 25'h0008030}; td = '{8'h11, 8'h22, 8'h33};
      run_dl(1'b1);
      ta = '{25'h0000000, 25'h0000001, 25'h0000002, 25'h0000003, 25'h0000004};
      td = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_dl(1'b1);
      for (int n = 0; n < 30; n++) begin
         ta.delete();
         td.delete();
         repeat ($urandom_range(1, 4)) begin
            ta.push_back({11'($urandom_range(0, 7)), 14'($urandom)});
            td.push_back(8'($urandom));
         end
         run_dl(1'b0);
      end
      tick();
      ioctl_download = 1'b1;
      ioctl_index = 8'h3C;
      tick();
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h0000100;
      tick();
      ioctl_wr = 1'b0;
      repeat (2) tick();
      check("foreign_index", {busy, hold_reset, mem_we}, 0);
      ioctl_download = 1'b0;
      ioctl_index = 8'h00;
      hold_ack = 1'b1;
      tick();
      ioctl_download = 1'b1;
      tick();
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h0000000;
      ioctl_dout = 8'h77;
      tick();
      ioctl_wr = 1'b0;
      check("we_before_reset", {mem_we, mem_din}, {1'b1, 8'h77});
      reset = 1'b1;
      ioctl_download = 1'b0;
      tick();
      reset = 1'b0;
      check("reset_mid_write", {mem_we, busy, hold_reset, done, err_ovf, pages, checksum, mem_addr, mem_bank, mem_din}, 0);
      mem_ack = 1'b1;
      repeat (2) tick();
      mem_ack = 1'b0;
      check("ack_ignored", mem_we, 0);
      hold_ack = 1'b0;
      repeat (2) tick();
      check("no_retry", mem_we, 0);
      ta = '{25'h0014000}; td = '{8'h9E};
      run_dl(1'b0);
      repeat (4) tick();
      check("write_count", n_wr, e_wr);
      check("done_count", n_done, e_done);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
